// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : Adds or subtracts two WIDTH-bit operands by running one 4-bit
//            adder slice over WIDTH/4 cycles, LSB nibble first. The carry
//            between nibbles passes through a register. The module uses a
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================

module Four_Bit_Full_Adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  // Plain 4-bit ripple add. The result is widened to 5 bits to keep the carry.
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_opa, r_opb, r_res;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf;

  logic             w_accept, w_last;
  logic [IDXW+1:0]  w_bitpos;
  logic [3:0]       w_a_nib, w_b_nib, w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_res_next;

  // A new request is taken only when the previous one has finished.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_idx == c_LAST_IDX);
  assign w_bitpos = {r_idx, 2'b00};
  assign w_a_nib  = r_opa[w_bitpos +: 4];
  assign w_b_nib  = r_opb[w_bitpos +: 4];

  Four_Bit_Full_Adder u_slice (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .Cin  (r_carry),
    .Sum  (w_slice_sum),
    .Cout (w_slice_cout)
  );

  // Build the result with the current nibble already replaced, so completion
  // can publish it in the same edge.
  always_comb begin
    w_res_next = r_res;
    w_res_next[w_bitpos +: 4] = w_slice_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic. Start is ignored while in RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (w_last)   w_next_state = S_DONE;
      S_DONE:  w_next_state = w_accept ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand latch, nibble sequencing, and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // For subtraction, invert B and force carry-in to 1. This computes A - B.
      r_opa   <= A;
      r_opb   <= B ^ {WIDTH{Sub}};
      r_carry <= Sub ? 1'b1 : Cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_res   <= w_res_next;
      r_carry <= w_slice_cout;
      r_idx   <= r_idx + IDXW'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_slice_cout;
        r_ovf  <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                  (w_res_next[WIDTH-1] != r_opa[WIDTH-1]);
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Directed self-checking bench for nibble_serial_adder_ctrl with
//            WIDTH=16. Expected values are computed by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, Sub, Cin;
  logic [15:0] A, B;
  logic        busy, done, Cout, Overflow;
  logic [15:0] Sum;

  int vectors = 0;
  int miscompares = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .Sub      (Sub),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .busy     (busy),
    .done     (done),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow)
  );

  // 10-time-unit clock period.
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all result outputs at once.
  task automatic chk_result(input string tag, input logic [15:0] s, input logic c, input logic v);
    chk({tag, ".Sum"}, {16'h0, Sum}, {16'h0, s});
    chk({tag, ".Cout"}, {31'h0, Cout}, {31'h0, c});
    chk({tag, ".Ovf"}, {31'h0, Overflow}, {31'h0, v});
  endtask

  // Run one operation from IDLE.
  // The task checks busy for 4 cycles, that the previous Sum is held,
  // and then the done pulse and the result.
  // Operands are scrambled after the accepting edge to show they are latched.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec, input logic ev);
    logic [15:0] prev;
    @(negedge clk);
    prev = Sum;
    A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      A = ~a; B = ~b; Cin = ~cin; Sub = ~sub;
      chk({tag, ".busy"}, {31'h0, busy}, 32'h1);
      chk({tag, ".done_lo"}, {31'h0, done}, 32'h0);
      chk({tag, ".held"}, {16'h0, Sum}, {16'h0, prev});
    end
    @(negedge clk);
    chk({tag, ".done"}, {31'h0, done}, 32'h1);
    chk({tag, ".busy_lo"}, {31'h0, busy}, 32'h0);
    chk_result(tag, es, ec, ev);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; Sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    chk_result("rst", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;

    run_op("add",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovfpos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovfneg", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub5m7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub7m5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("add_c",  16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0);

    // A start pulse during RUN is ignored.
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign.busy", {31'h0, busy}, 32'h1);
    chk("ign.held", {16'h0, Sum}, 16'h0008);
    @(negedge clk);
    A = 16'h1111; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign.busy2", {31'h0, busy}, 32'h1);
    repeat (2) @(negedge clk);
    chk("ign.done", {31'h0, done}, 32'h1);
    chk_result("ign", 16'h0002, 1'b0, 1'b0);

    // A start during the done cycle is accepted with no idle gap.
    A = 16'h0010; B = 16'h0020; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.busy", {31'h0, busy}, 32'h1);
    chk("b2b.done_lo", {31'h0, done}, 32'h0);
    chk("b2b.held", {16'h0, Sum}, 16'h0002);
    repeat (3) @(negedge clk);
    chk("b2b.busy4", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("b2b.done", {31'h0, done}, 32'h1);
    chk_result("b2b", 16'h0030, 1'b0, 1'b0);

    // Reset at the second RUN edge aborts the operation.
    @(negedge clk);
    A = 16'hAAAA; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.busy", {31'h0, busy}, 32'h0);
    chk("abort.done", {31'h0, done}, 32'h0);
    chk_result("abort", 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort.nodone", {31'h0, done}, 32'h0);
    end
    run_op("post", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
